// File: rtl/ifetch_queue.sv
// Fetch queue: issues sequential imem reads and buffers {pc, instr} for decode; redirect flushes and drops stale responses.
// Latency: response to dec_valid is 1 cycle (0 cycles with FETCHQ_BYPASS_EN when the queue is empty and nothing is being dropped).
// Backpressure: requests are credit-limited (count + inflight < DEPTH) so responses are never stalled; decode uses valid/ready.
module ifetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [ADDR_WIDTH-1:0]      imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]      imem_rsp_data,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [DATA_WIDTH-1:0]      dec_instr,
    output logic [ADDR_WIDTH-1:0]      dec_pc,
    output logic [$clog2(DEPTH):0]     fq_count
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

    // Occupancy, outstanding requests and number of stale responses still to discard.
    logic [CW-1:0]         count;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         drop_cnt;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];

    logic credit_ok;
    logic accept;
    logic rsp_ok;
    logic rsp_keep;
    logic fifo_valid;
    logic byp;
    logic pop;
    logic push;

    // Handshake decode: credits, response classification, bypass and FIFO push/pop.
    always_comb begin
        credit_ok  = ({1'b0, count} + {1'b0, inflight}) < DEPTH_W;
        // rst gate keeps the request low while reset is held, independent of state.
        accept     = 1'b0;
        rsp_ok     = imem_rsp_valid && (inflight != '0);
        rsp_keep   = rsp_ok && (drop_cnt == '0) && !redirect_valid;
        fifo_valid = (count != '0);
`ifdef FETCHQ_BYPASS_EN
        byp        = rsp_keep && !fifo_valid;
`else
        byp        = 1'b0;
`endif
        imem_req_valid = !rst && !redirect_valid && credit_ok;
        accept         = imem_req_valid && imem_req_ready;
        imem_req_addr  = req_pc;
        dec_valid      = fifo_valid || byp;
        dec_instr      = fifo_valid ? mem_data[rd_ptr] : imem_rsp_data;
        dec_pc         = fifo_valid ? mem_pc[rd_ptr]   : rsp_pc;
        pop            = fifo_valid && dec_ready;
        // A bypassed word taken by decode this cycle never enters the FIFO.
        push           = rsp_keep && !(byp && dec_ready);
        fq_count       = count;
    end

    // Control state: PCs, credits, drop counter, FIFO pointers; redirect has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc   <= RESET_PC;
            rsp_pc   <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(rsp_ok);
            if (redirect_valid) begin
                req_pc   <= redirect_pc;
                rsp_pc   <= redirect_pc;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                // Everything still outstanding after this cycle is stale.
                drop_cnt <= inflight + CW'(accept) - CW'(rsp_ok);
            end else begin
                if (accept) begin
                    req_pc <= req_pc + ADDR_WIDTH'(4);
                end
                if (rsp_ok) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - CW'(1);
                    end else begin
                        rsp_pc <= rsp_pc + ADDR_WIDTH'(4);
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO storage; contents beyond count are don't-care, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !redirect_valid) begin
            mem_data[wr_ptr] <= imem_rsp_data;
            mem_pc[wr_ptr]   <= rsp_pc;
        end
    end

    // A response with nothing outstanding is ignored by the logic above; flag it in simulation.
    rsp_protocol: assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && inflight == '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: the bench plays instruction memory and decode, and checks against a queue model.
// The model tracks outstanding requests (with a stale flag set by redirect) and the buffered words in plain queues.
// Data returned for address a is a fixed hash of a, so every decoded word can be checked against its PC.
module tb_ifetch_queue;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          dec_valid;
    logic          dec_ready;
    logic [DW-1:0] dec_instr;
    logic [AW-1:0] dec_pc;
    logic [CW-1:0] fq_count;

    ifetch_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fq_count       (fq_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        oq[$];
    ent_t        fq[$];
    logic [31:0] exp_req;
    int          cyc;
    int          last_due;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Assert reset away from the clock edge and check the asynchronous effect before any edge.
    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        dec_ready      = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
        check_eq("rst_fq_count",  32'(fq_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        oq.delete();
        fq.delete();
        exp_req  = '0;
        cyc      = 0;
        last_due = -1;
    endtask

    // One cycle: drive inputs, predict and compare outputs at negedge, advance the model.
    task automatic run_cycle(input int p_req, input int p_dec, input int p_redir, input int lat_max,
                             output bit hs);
        bit          e_req_vld, rsp_keep, byp, e_dec_vld;
        ent_t        head;
        req_t        r;
        int          due;
        redirect_valid = ($urandom_range(999) < p_redir);
        case ($urandom_range(3))
            0:       redirect_pc = 32'hFFFF_FFF4;
            1:       redirect_pc = 32'h0000_0100;
            default: redirect_pc = $urandom & 32'hFFFF_FFFC;
        endcase
        imem_req_ready = ($urandom_range(99) < p_req);
        dec_ready      = ($urandom_range(99) < p_dec);
        if (oq.size() > 0 && oq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(oq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        e_req_vld = !redirect_valid && (fq.size() + oq.size() < DEPTH);
        rsp_keep  = imem_rsp_valid && !oq[0].stale && !redirect_valid;
        byp       = BYP && rsp_keep && (fq.size() == 0);
        e_dec_vld = (fq.size() != 0) || byp;
        if (fq.size() != 0) head = fq[0];
        else if (imem_rsp_valid) head = '{oq[0].addr, mem_word(oq[0].addr)};
        else head = '{32'd0, 32'd0};

        check_eq("req_valid", 32'(imem_req_valid), 32'(e_req_vld));
        if (e_req_vld) check_eq("req_addr", imem_req_addr, exp_req);
        check_eq("dec_valid", 32'(dec_valid), 32'(e_dec_vld));
        if (e_dec_vld) begin
            check_eq("dec_pc",    dec_pc,    head.pc);
            check_eq("dec_instr", dec_instr, head.instr);
        end
        check_eq("fq_count", 32'(fq_count), 32'(fq.size()));

        hs = e_dec_vld && dec_ready;
        if (imem_rsp_valid) r = oq.pop_front();
        if (hs && fq.size() != 0) void'(fq.pop_front());
        if (rsp_keep && !(byp && dec_ready)) fq.push_back('{r.addr, mem_word(r.addr)});
        if (e_req_vld && imem_req_ready) begin
            due = cyc + $urandom_range(lat_max, 1);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            oq.push_back('{exp_req, due, 1'b0});
            exp_req = exp_req + 32'd4;
        end
        if (redirect_valid) begin
            fq.delete();
            foreach (oq[k]) oq[k].stale = 1'b1;
            exp_req = redirect_pc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Phase table: cycles, req_ready %, dec_ready %, redirect per-mille, max imem latency.
    int ph_n     [7] = '{200, 40, 60, 400, 400, 300, 300};
    int ph_req   [7] = '{100, 100, 100, 60, 90, 30, 100};
    int ph_dec   [7] = '{100, 0, 100, 70, 90, 50, 100};
    int ph_redir [7] = '{0, 0, 0, 50, 100, 30, 200};
    int ph_lat   [7] = '{1, 1, 1, 3, 2, 4, 1};

    initial begin
        bit hs;
        int hs_cnt;
        rst = 1'b1;
        do_reset();
        for (int p = 0; p < 7; p++) begin
            if (p == 3) do_reset();
            hs_cnt = 0;
            for (int i = 0; i < ph_n[p]; i++) begin
                run_cycle(ph_req[p], ph_dec[p], ph_redir[p], ph_lat[p], hs);
                if (hs) hs_cnt++;
            end
            // Streaming from reset with 1-cycle memory: one hand-off per cycle after a 2-cycle fill.
            if (p == 0) check_eq("throughput", 32'(hs_cnt >= ph_n[0] - 2), 32'd1);
            // Decode stalled: the queue fills to DEPTH and requests stop.
            if (p == 1) begin
                check_eq("full_count",     32'(fq_count), 32'(DEPTH));
                check_eq("full_req_valid", 32'(imem_req_valid), 32'd0);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
